// File: rtl/dp_operand_driver_if.sv
// Operand/result streams plus the datapath operand/result bus for dp_operand_driver.
// The driver takes the slave side; the producer/consumer/datapath environment takes master.
interface dp_operand_driver_if #(
    parameter int DATAWIDTH = 8,
    parameter int RESWIDTH  = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_a, in_b, in_c;
    logic [DATAWIDTH-1:0] dp_a, dp_b, dp_c;
    logic [DATAWIDTH-1:0] dp_z;
    logic [RESWIDTH-1:0]  dp_x;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_z;
    logic [RESWIDTH-1:0]  out_x;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_c, dp_z, dp_x, out_ready,
        input  in_ready, dp_a, dp_b, dp_c, out_valid, out_z, out_x, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, dp_z, dp_x, out_ready,
        output in_ready, dp_a, dp_b, dp_c, out_valid, out_z, out_x, busy
    );
endinterface

// File: rtl/dp_operand_driver.sv
// Buffers operand triplets, issues them one at a time to a combinational datapath,
// waits LAT settle cycles, captures z/x and hands them out over a valid/ready stream.
module dp_operand_driver #(
    parameter int DATAWIDTH = 8,
    parameter int RESWIDTH  = 16,
    parameter int DEPTH     = 4,
    parameter int LAT       = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    dp_operand_driver_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef struct packed {
        logic [DATAWIDTH-1:0] a;
        logic [DATAWIDTH-1:0] b;
        logic [DATAWIDTH-1:0] c;
    } trip_t;

    trip_t         mem [DEPTH];
    trip_t         head;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          push, pop, nonempty;

    assign head         = mem[rptr];
    assign nonempty     = (count != '0);
    // No bypass: readiness depends on the registered count only.
    assign bus.in_ready = (count < CW'(DEPTH)) && !Rst;
    assign push         = bus.in_valid && bus.in_ready;
    // The only consumer of the FIFO is the issue action.
    assign pop          = nonempty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    assign bus.busy     = (state != IDLE) || nonempty;

    always_ff @(posedge Clk) begin
        if (push)
            mem[wptr] <= '{a: bus.in_a, b: bus.in_b, c: bus.in_c};
    end

    // DEPTH is a power of two, so the pointers wrap on plain overflow.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.dp_a      <= '0;
            bus.dp_b      <= '0;
            bus.dp_c      <= '0;
            bus.out_z     <= '0;
            bus.out_x     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            if (pop) begin
                bus.dp_a <= head.a;
                bus.dp_b <= head.b;
                bus.dp_c <= head.c;
                cnt      <= 4'(LAT);
            end
            case (state)
                IDLE: begin
                    if (nonempty) state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        bus.out_z     <= bus.dp_z;
                        bus.out_x     <= bus.dp_x;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= nonempty ? WAIT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_operand_driver.sv
// Bench for dp_operand_driver: two instances (LAT=1 and LAT=3) driving a signed
// three-operand datapath model; directed tables, corner sequences and random traffic.
module tb_dp_operand_driver;
    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    dp_operand_driver_if #(.DATAWIDTH(8), .RESWIDTH(16)) ifc1 ();
    dp_operand_driver_if #(.DATAWIDTH(8), .RESWIDTH(16)) ifc3 ();

    dp_operand_driver #(.DATAWIDTH(8), .RESWIDTH(16), .DEPTH(4), .LAT(1)) u1 (
        .Clk(Clk), .Rst(Rst), .bus(ifc1.slave));
    dp_operand_driver #(.DATAWIDTH(8), .RESWIDTH(16), .DEPTH(4), .LAT(3)) u3 (
        .Clk(Clk), .Rst(Rst), .bus(ifc3.slave));

    // Datapath: d=a+b, e=a+c, z=max(d,e), x=a*c-d, all signed Int8 with Int16 x.
    function automatic logic [23:0] dpf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic signed [7:0]  sa, sc, d, e, z;
        logic signed [15:0] x;
        sa = a; sc = c;
        d = a + b;
        e = a + c;
        z = (d > e) ? d : e;
        x = sa * sc - d;
        return {z, x};
    endfunction

    logic [23:0] r1, r3;
    assign r1 = dpf(ifc1.dp_a, ifc1.dp_b, ifc1.dp_c);
    assign r3 = dpf(ifc3.dp_a, ifc3.dp_b, ifc3.dp_c);
    assign ifc1.dp_z = r1[23:16];
    assign ifc1.dp_x = r1[15:0];
    assign ifc3.dp_z = r3[23:16];
    assign ifc3.dp_x = r3[15:0];

    int vec = 0;
    int miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Scoreboards: pushed triplets in order, results checked against dpf().
    logic [23:0] q1[$], q3[$];
    int res1 = 0, psh1 = 0, res3 = 0, psh3 = 0, vhi3 = 0, cyc3 = 0;
    int last_iss3 = 0, last_res3 = 0;
    logic pv1 = 1'b0, pv3 = 1'b0, tim3 = 1'b0, first3 = 1'b1;
    logic [23:0] pz1, pz3, pdp3 = '0;

    always @(negedge Clk) begin
        logic [23:0] t;
        if (Rst) begin
            q1.delete();
            pv1 = 1'b0;
        end else begin
            if (pv1) chk("hold1", 32'({ifc1.out_valid, ifc1.out_z, ifc1.out_x}), 32'({1'b1, pz1}));
            if (ifc1.in_valid && ifc1.in_ready) begin
                q1.push_back({ifc1.in_a, ifc1.in_b, ifc1.in_c});
                psh1++;
            end
            if (ifc1.out_valid && ifc1.out_ready) begin
                if (q1.size() == 0) chk("spurious1", 32'(q1.size()), 32'd1);
                else begin
                    t = q1.pop_front();
                    chk("res1", 32'({ifc1.out_z, ifc1.out_x}), 32'(dpf(t[23:16], t[15:8], t[7:0])));
                end
                res1++;
            end
            pv1 = ifc1.out_valid && !ifc1.out_ready;
            pz1 = {ifc1.out_z, ifc1.out_x};
        end
    end

    always @(negedge Clk) begin
        logic [23:0] t;
        cyc3++;
        if (Rst) begin
            q3.delete();
            pv3  = 1'b0;
            pdp3 = {ifc3.dp_a, ifc3.dp_b, ifc3.dp_c};
        end else begin
            if (pv3) chk("hold3", 32'({ifc3.out_valid, ifc3.out_z, ifc3.out_x}), 32'({1'b1, pz3}));
            if (ifc3.in_valid && ifc3.in_ready) begin
                q3.push_back({ifc3.in_a, ifc3.in_b, ifc3.in_c});
                psh3++;
            end
            if ({ifc3.dp_a, ifc3.dp_b, ifc3.dp_c} != pdp3) last_iss3 = cyc3;
            pdp3 = {ifc3.dp_a, ifc3.dp_b, ifc3.dp_c};
            if (ifc3.out_valid) vhi3++;
            if (ifc3.out_valid && ifc3.out_ready) begin
                if (q3.size() == 0) chk("spurious3", 32'(q3.size()), 32'd1);
                else begin
                    t = q3.pop_front();
                    chk("res3", 32'({ifc3.out_z, ifc3.out_x}), 32'(dpf(t[23:16], t[15:8], t[7:0])));
                end
                if (tim3) begin
                    chk("settle3", 32'(cyc3 - last_iss3), 32'd3);
                    if (!first3) chk("spacing3", 32'(cyc3 - last_res3), 32'd4);
                    first3 = 1'b0;
                end
                last_res3 = cyc3;
                res3++;
            end
            pv3 = ifc3.out_valid && !ifc3.out_ready;
            pz3 = {ifc3.out_z, ifc3.out_x};
        end
    end

    task automatic drain1;
        int g;
        ifc1.in_valid = 1'b0;
        ifc1.out_ready = 1'b1;
        g = 0;
        while ((ifc1.busy || ifc1.out_valid) && g < 200) begin tick; g++; end
        chk("drain1_timeout", 32'(g < 200), 32'd1);
        ifc1.out_ready = 1'b0;
    endtask

    task automatic drain3;
        int g;
        ifc3.in_valid = 1'b0;
        ifc3.out_ready = 1'b1;
        g = 0;
        while ((ifc3.busy || ifc3.out_valid) && g < 200) begin tick; g++; end
        chk("drain3_timeout", 32'(g < 200), 32'd1);
        ifc3.out_ready = 1'b0;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int g;
        ifc3.in_valid = 1'b1;
        ifc3.in_a = a; ifc3.in_b = b; ifc3.in_c = c;
        g = 0;
        while (!ifc3.in_ready && g < 50) begin tick; g++; end
        chk("push3_timeout", 32'(g < 50), 32'd1);
        tick;
        ifc3.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a, b, c, z;
        logic [15:0] x;
    } vec_t;
    vec_t tv[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        tv[0] = '{a: 8'd3,   b: 8'd4,   c: 8'd5,   z: 8'h08, x: 16'h0008};
        tv[1] = '{a: 8'd10,  b: 8'd20,  c: 8'd2,   z: 8'h1E, x: 16'hFFF6};
        tv[2] = '{a: 8'hFF,  b: 8'h01,  c: 8'hFF,  z: 8'h00, x: 16'h0001};
        tv[3] = '{a: 8'd100, b: 8'd100, c: 8'd0,   z: 8'h64, x: 16'h0038};
        tv[4] = '{a: 8'h80,  b: 8'h00,  c: 8'h80,  z: 8'h00, x: 16'h4080};
        tv[5] = '{a: 8'h7F,  b: 8'h00,  c: 8'h7F,  z: 8'h7F, x: 16'h3E82};

        Rst = 1'b1;
        ifc1.in_valid = 1'b0; ifc1.in_a = '0; ifc1.in_b = '0; ifc1.in_c = '0; ifc1.out_ready = 1'b0;
        ifc3.in_valid = 1'b0; ifc3.in_a = '0; ifc3.in_b = '0; ifc3.in_c = '0; ifc3.out_ready = 1'b0;
        repeat (2) tick;
        chk("rst_in_ready", 32'(ifc1.in_ready), 32'd0);
        chk("rst_out_valid", 32'(ifc1.out_valid), 32'd0);
        chk("rst_busy", 32'(ifc1.busy), 32'd0);
        chk("rst_dp", 32'({ifc1.dp_a, ifc1.dp_b, ifc1.dp_c}), 32'd0);
        chk("rst_out", 32'({ifc1.out_z, ifc1.out_x}), 32'd0);
        chk("rst_out3", 32'({ifc3.out_valid, ifc3.out_z, ifc3.out_x}), 32'd0);
        Rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(ifc1.in_ready), 32'd1);

        // Single ops, LAT=1: issue one edge after push, result one edge after issue.
        for (int i = 0; i < 6; i++) begin
            ifc1.in_valid = 1'b1;
            ifc1.in_a = tv[i].a; ifc1.in_b = tv[i].b; ifc1.in_c = tv[i].c;
            tick;
            ifc1.in_valid = 1'b0;
            chk("single_no_early_valid", 32'(ifc1.out_valid), 32'd0);
            tick;
            chk("single_dp", 32'({ifc1.dp_a, ifc1.dp_b, ifc1.dp_c}), 32'({tv[i].a, tv[i].b, tv[i].c}));
            chk("single_wait_valid", 32'(ifc1.out_valid), 32'd0);
            tick;
            chk("single_valid", 32'(ifc1.out_valid), 32'd1);
            chk("single_result", 32'({ifc1.out_z, ifc1.out_x}), 32'({tv[i].z, tv[i].x}));
            ifc1.out_ready = 1'b1;
            tick;
            ifc1.out_ready = 1'b0;
            chk("single_done", 32'({ifc1.out_valid, ifc1.busy}), 32'd0);
            chk("single_dp_hold", 32'({ifc1.dp_a, ifc1.dp_b, ifc1.dp_c}), 32'({tv[i].a, tv[i].b, tv[i].c}));
        end

        // Fill with the consumer stalled: one in HOLD, four queued, sixth refused.
        r = res1;
        for (int k = 0; k < 5; k++) begin
            ifc1.in_valid = 1'b1;
            ifc1.in_a = 8'(k + 1); ifc1.in_b = 8'(2 * k); ifc1.in_c = 8'(k + 7);
            tick;
        end
        ifc1.in_a = 8'd50; ifc1.in_b = 8'd60; ifc1.in_c = 8'd70;
        chk("full_in_ready", 32'(ifc1.in_ready), 32'd0);
        chk("full_hold", 32'({ifc1.out_valid, ifc1.busy}), 32'd3);
        chk("full_psh", 32'(psh1 - r), 32'd5);
        repeat (3) begin
            tick;
            chk("full_stays_blocked", 32'(ifc1.in_ready), 32'd0);
        end
        ifc1.out_ready = 1'b1;
        tick;
        ifc1.out_ready = 1'b0;
        chk("full_no_bypass_then_ready", 32'(ifc1.in_ready), 32'd1);
        chk("full_no_bypass_push", 32'(psh1 - r), 32'd5);
        tick;
        drain1;
        chk("full_results", 32'(res1 - r), 32'd6);
        chk("full_sb_empty", 32'(q1.size()), 32'd0);

        // Push and pop on the same edge at count=DEPTH-1.
        r = res1;
        for (int k = 0; k < 4; k++) begin
            ifc1.in_valid = 1'b1;
            ifc1.in_a = 8'(8'hA0 + k); ifc1.in_b = 8'(k); ifc1.in_c = 8'(8'h11 * k);
            tick;
        end
        chk("pp_pre_ready", 32'({ifc1.in_ready, ifc1.out_valid}), 32'd3);
        ifc1.in_a = 8'hB4; ifc1.in_b = 8'h04; ifc1.in_c = 8'h44;
        ifc1.out_ready = 1'b1;
        tick;
        chk("pp_ready_kept", 32'(ifc1.in_ready), 32'd1);
        ifc1.in_a = 8'hB5; ifc1.in_b = 8'h05; ifc1.in_c = 8'h55;
        ifc1.out_ready = 1'b0;
        tick;
        chk("pp_count_was_3", 32'(ifc1.in_ready), 32'd0);
        drain1;
        chk("pp_results", 32'(res1 - r), 32'd6);

        // Streaming on LAT=3 with out_ready high: 4-cycle result spacing.
        r = res3;
        ifc3.out_ready = 1'b1;
        first3 = 1'b1;
        tim3 = 1'b1;
        for (int k = 0; k < 8; k++) push3(8'(8'h10 + 3 * k), 8'(k), 8'(8'hF0 - k));
        drain3;
        tim3 = 1'b0;
        chk("stream_results", 32'(res3 - r), 32'd8);

        // Reset while waiting with three queued.
        r = res3;
        for (int k = 0; k < 4; k++) begin
            ifc3.in_valid = 1'b1;
            ifc3.in_a = 8'(8'h21 + k); ifc3.in_b = 8'(8'h31 + k); ifc3.in_c = 8'(8'h41 + k);
            tick;
        end
        ifc3.in_valid = 1'b0;
        chk("mid_busy_wait", 32'({ifc3.busy, ifc3.out_valid}), 32'd2);
        Rst = 1'b1;
        tick;
        chk("mid_rst_out_valid", 32'(ifc3.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(ifc3.busy), 32'd0);
        chk("mid_rst_dp", 32'({ifc3.dp_a, ifc3.dp_b, ifc3.dp_c}), 32'd0);
        Rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ifc3.in_ready), 32'd1);
        r = vhi3;
        ifc3.out_ready = 1'b1;
        repeat (10) tick;
        chk("mid_no_stale_valid", 32'(vhi3 - r), 32'd0);
        ifc3.out_ready = 1'b0;

        // Random traffic on both instances.
        psh1 = 0; res1 = 0; psh3 = 0; res3 = 0;
        fork
            begin
                logic hs;
                for (int n = 0; n < 400; n++) begin
                    hs = ifc1.in_valid && ifc1.in_ready;
                    tick;
                    if (!ifc1.in_valid || hs) begin
                        ifc1.in_valid = ($urandom_range(0, 2) != 0);
                        ifc1.in_a = 8'($urandom); ifc1.in_b = 8'($urandom); ifc1.in_c = 8'($urandom);
                    end
                    ifc1.out_ready = ($urandom_range(0, 3) != 0);
                end
                drain1;
            end
            begin
                logic hs;
                for (int n = 0; n < 400; n++) begin
                    hs = ifc3.in_valid && ifc3.in_ready;
                    tick;
                    if (!ifc3.in_valid || hs) begin
                        ifc3.in_valid = ($urandom_range(0, 1) != 0);
                        ifc3.in_a = 8'($urandom); ifc3.in_b = 8'($urandom); ifc3.in_c = 8'($urandom);
                    end
                    ifc3.out_ready = ($urandom_range(0, 2) != 0);
                end
                drain3;
            end
        join
        chk("rand1_all_returned", 32'(res1), 32'(psh1));
        chk("rand3_all_returned", 32'(res3), 32'(psh3));
        chk("rand_sb_empty", 32'(q1.size() + q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/dp_operand_driver.md
Name: dp_operand_driver

Overview:
- Sequential front/back end for the generated combinational datapath circuits, such as the three-operand Int8-in / Int8 + Int16-out datapath.
- Accepts operand triplets over a valid/ready stream and buffers them in a small FIFO.
- Issues one triplet at a time to the datapath, waits a fixed settle latency, then captures the results.
- Returns the results over a second valid/ready stream.

Parameters:
- DATAWIDTH, 8, width of operands a, b, c and of result z.
- RESWIDTH, 16, width of result x.
- DEPTH, 4, input FIFO entries (power of 2, >=2).
- LAT, 1, cycles the datapath is given to settle after operands change (>=1, <=15).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand triplet offered.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH) and !Rst.
- in_a, in_b, in_c  in  DATAWIDTH  operands.
- dp_a, dp_b, dp_c  out  DATAWIDTH  registered operands driven to the datapath.
- dp_z  in  DATAWIDTH  datapath result z.
- dp_x  in  RESWIDTH  datapath result x.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_z  out  DATAWIDTH  captured z.
- out_x  out  RESWIDTH  captured x.
- busy  out  1  high when state != IDLE or FIFO non-empty.

Behaviour:
- Reset (Rst high at an edge):
  - FIFO emptied (pointers and count = 0); state = IDLE; wait counter = 0.
  - dp_a/b/c = 0, out_z = 0, out_x = 0, out_valid = 0.
  - in_ready = 0 while Rst is high and 1 on the first cycle after.
- Reset mid-operation discards all queued triplets, any in-flight issue and any held result. No output pulses.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only by the FSM issue action.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - in_ready is computed from registered count only. No bypass when full: a pop in the same cycle does not make in_ready high.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, WAIT, HOLD:
  - IDLE: if FIFO non-empty, then at the edge dp_a/b/c <= head, pop, cnt <= LAT, go to WAIT. Otherwise stay.
  - WAIT: if cnt == 1, then out_z <= dp_z, out_x <= dp_x, out_valid <= 1, go to HOLD. Otherwise cnt <= cnt - 1. The datapath therefore sees stable operands for exactly LAT cycles before capture.
  - HOLD: out_valid = 1 and out_z/out_x stable until out_ready.
    - On out_valid && out_ready with FIFO non-empty: out_valid <= 0 and issue the next triplet in the same edge (dp load, pop, cnt <= LAT, go to WAIT).
    - On out_valid && out_ready with FIFO empty: out_valid <= 0, go to IDLE.
- dp_a/b/c change only on an issue edge. They hold their last value otherwise, including in IDLE.
- Latency:
  - A triplet pushed at edge N into an empty, idle block issues at edge N+1.
  - Its result is captured with out_valid high after edge N+1+LAT.
  - Steady-state throughput with out_ready tied high: one result per LAT+1 cycles.
- Results are captured verbatim, with no width conversion. Results return in push order (no reordering, no drops).
- in_valid with in_ready low: the triplet is not taken and the producer must hold it.

Test Plan:
1. Reset then single op, LAT=1, datapath model d=a+b, e=a+c, z=(d>e)?d:e, x=a*c-d: push a=3, b=4, c=5 -> dp_a/b/c=3/4/5 one edge after the push; out_valid one edge later with out_z=8, out_x=16'h0008.
2. Signed wrap of x: push a=10, b=20, c=2 -> out_z=30 (8'h1E), out_x=16'hFFF6.
3. Fill and backpressure: out_ready=0, push 6 triplets back-to-back -> 1 issues into HOLD, FIFO takes 4, in_ready=0 for the 6th until out_ready pulses. All results then arrive in order.
4. Streaming, out_ready=1, LAT=3, 8 distinct triplets -> results spaced every 4 cycles, in order; dp_* stable for 3 cycles each.
5. Simultaneous push/pop at count=DEPTH-1 -> count stays DEPTH-1, in_ready stays 1, no loss or duplication.
6. Rst asserted in WAIT with 3 queued triplets -> next cycle: out_valid=0, busy=0, dp_*=0, in_ready=1; no stale result appears afterwards.
